// File: rtl/secure_strobe_router.sv
// secure_strobe_router
//   Multi-channel keyed router with brute-force lockout. Each strobed word
//   {key, chan, data} carrying the correct key and an in-range channel is
//   written into that channel's output slice and pulses its valid bit.
//   MAX_FAIL consecutive rejected words lock the router for LOCK_CYC cycles,
//   during which all strobes are ignored.
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset
//   strobe    in   qualifies d_in for one cycle
//   d_in      in   {key, chan, data}, key in the MSBs
//   d_out     out  channel c in bits [c*DATA_W +: DATA_W]
//   out_valid out  one-cycle pulse per updated channel
//   locked    out  high while locked out
//   fail_cnt  out  consecutive rejected words
module secure_strobe_router #(
    parameter int              DATA_W   = 4,
    parameter int              KEY_W    = 2,
    parameter logic [KEY_W-1:0] KEY_VAL = '0,
    parameter int              NUM_CH   = 4,
    parameter int              MAX_FAIL = 3,
    parameter int              LOCK_CYC = 8,
    localparam int             CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int             FC_W     = $clog2(MAX_FAIL + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       strobe,
    input  logic [KEY_W+CH_W+DATA_W-1:0] d_in,
    output logic [NUM_CH*DATA_W-1:0]   d_out,
    output logic [NUM_CH-1:0]          out_valid,
    output logic                       locked,
    output logic [FC_W-1:0]            fail_cnt
);

    localparam int IN_W = KEY_W + CH_W + DATA_W;
    localparam int LC_W = $clog2(LOCK_CYC + 1);
    // One extra bit so NUM_CH itself is representable for the range check;
    // for power-of-two NUM_CH the comparison folds to constant true.
    localparam logic [CH_W:0] NUM_CH_X = (CH_W + 1)'(NUM_CH);

    typedef enum logic [0:0] {
        ACTIVE = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t                    state_q, state_d;
    logic [LC_W-1:0]           lock_cnt, lock_d;
    logic [NUM_CH*DATA_W-1:0]  dout_d;
    logic [NUM_CH-1:0]         valid_d;
    logic [FC_W-1:0]           fail_d;

    logic [KEY_W-1:0]  key;
    logic [CH_W-1:0]   chan;
    logic [DATA_W-1:0] data;
    logic              good;

    assign key  = d_in[IN_W-1 -: KEY_W];
    assign chan = d_in[DATA_W +: CH_W];
    assign data = d_in[DATA_W-1:0];
    assign good = (key == KEY_VAL) && ({1'b0, chan} < NUM_CH_X);

    always_comb begin
        state_d = state_q;
        dout_d  = d_out;
        valid_d = '0;
        fail_d  = fail_cnt;
        lock_d  = lock_cnt;
        case (state_q)
            ACTIVE: begin
                if (strobe) begin
                    if (good) begin
                        for (int c = 0; c < NUM_CH; c++) begin
                            if (chan == CH_W'(c)) begin
                                dout_d[c*DATA_W +: DATA_W] = data;
                                valid_d[c]                 = 1'b1;
                            end
                        end
                        fail_d = '0;
                    end else if (fail_cnt == FC_W'(MAX_FAIL - 1)) begin
                        fail_d  = FC_W'(MAX_FAIL);
                        state_d = LOCKED;
                        lock_d  = LC_W'(LOCK_CYC);
                    end else begin
                        fail_d = fail_cnt + FC_W'(1);
                    end
                end
            end
            LOCKED: begin
                // Counter is loaded with LOCK_CYC, so exiting on the edge that
                // sees 1 gives exactly LOCK_CYC locked cycles.
                if (lock_cnt == LC_W'(1)) begin
                    state_d = ACTIVE;
                    fail_d  = '0;
                    lock_d  = '0;
                end else begin
                    lock_d = lock_cnt - LC_W'(1);
                end
            end
            default: state_d = ACTIVE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ACTIVE;
            lock_cnt  <= '0;
            d_out     <= '0;
            out_valid <= '0;
            fail_cnt  <= '0;
            locked    <= 1'b0;
        end else begin
            state_q   <= state_d;
            lock_cnt  <= lock_d;
            d_out     <= dout_d;
            out_valid <= valid_d;
            fail_cnt  <= fail_d;
            locked    <= (state_d == LOCKED);
        end
    end

endmodule
